stack_unit: RTL

Hardware LIFO that terminates the register file's stack-push interface. It accepts `STACK_push_flag`/`STACK_push_value` and returns `STACK_TOP`/`STACK_AMOUNT`, which the register file exposes as the read-only registers `STACK_TOP_REG` and `STACK_AMOUNT_REG`. Pops come from the control path. The block holds the stack contents, occupancy count and error status, with all state registered on one clock.

---
 rtl/stack_unit_pkg.sv | 28 ++
 rtl/stack_unit_mem.sv | 35 +++
 rtl/stack_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stack_unit_pkg.sv
// Shared constants and types for the hardware LIFO and its register-file view.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_unit_pkg;

  // Register-file read-only register codes backed by this block
  localparam logic [7:0] STACK_TOP_REG    = 8'h20;
  localparam logic [7:0] STACK_AMOUNT_REG = 8'h21;

  // Occupancy counter width and default geometry
  localparam int STACK_AMOUNT_W = 16;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 256;

  // Operation decoded from {push, pop} request levels
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  // Address width for the DEPTH-1 entries held below the top register
  function automatic int mem_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/stack_unit_mem.sv
// Storage for the entries below the stack top: one sync write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from the register array.
// Backpressure: none; out-of-range reads return zero.
module stack_mem
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = mem_addr_w(DEF_DEPTH)
) (
  input  logic             clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam logic [AW:0] L_LAST_IDX = (AW + 1)'(DEPTH - 2);

  logic [WIDTH-1:0] r_mem [0:DEPTH-2];
  logic             w_rd_ok;

  // Store the displaced top entry; no reset because contents are don't-care when empty
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Register-array read so a pop sees the next-lower entry in the same cycle
  assign w_rd_ok   = ({1'b0, i_rd_addr} <= L_LAST_IDX);
  assign o_rd_data = w_rd_ok ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO with a dedicated top register, occupancy count and sticky error flags.
// Latency: every operation is visible right after the sampling edge; all outputs registered.
// Backpressure: none; full/empty are advisory, rejected ops only set sticky flags.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      STACK_push_flag,
  input  logic [WIDTH-1:0]          STACK_push_value,
  input  logic                      STACK_pop_flag,
  input  logic                      STACK_clear,
  output logic [WIDTH-1:0]          STACK_TOP,
  output logic [STACK_AMOUNT_W-1:0] STACK_AMOUNT,
  output logic                      STACK_full,
  output logic                      STACK_empty,
  output logic                      STACK_overflow,
  output logic                      STACK_underflow
);

  localparam int AW = mem_addr_w(DEPTH);
  localparam logic [STACK_AMOUNT_W-1:0] L_DEPTH = STACK_AMOUNT_W'(DEPTH);

  logic [WIDTH-1:0]          r_top;
  logic [STACK_AMOUNT_W-1:0] r_count;
  logic                      r_full;
  logic                      r_empty;
  logic                      r_ovf;
  logic                      r_unf;

  stack_op_e                 w_op;
  logic [WIDTH-1:0]          w_top_nxt;
  logic [STACK_AMOUNT_W-1:0] w_count_nxt;
  logic                      w_ovf_nxt;
  logic                      w_unf_nxt;
  logic                      w_wr_en;
  logic [AW-1:0]             w_wr_addr;
  logic [AW-1:0]             w_rd_addr;
  logic [WIDTH-1:0]          w_rd_data;

  assign w_op      = stack_op_e'({STACK_push_flag, STACK_pop_flag});
  // Old top goes to slot count-1 (new count-2); next-lower entry sits at count-2
  assign w_wr_addr = AW'(r_count - 16'd1);
  assign w_rd_addr = AW'(r_count - 16'd2);

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clock    (clock),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(r_top),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  // Next-state decode: clear beats push/pop; rejected ops only touch sticky flags
  always_comb begin
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_wr_en     = 1'b0;
    if (STACK_clear) begin
      w_top_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else begin
      unique case (w_op)
        OP_PUSH: begin
          if (r_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_top_nxt   = STACK_push_value;
            w_count_nxt = r_count + 16'd1;
            w_wr_en     = ~r_empty & ~reset;
          end
        end
        OP_POP: begin
          if (r_empty) begin
            w_unf_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count - 16'd1;
            w_top_nxt   = (r_count == 16'd1) ? '0 : w_rd_data;
          end
        end
        OP_REPL: begin
          // Replace top in place; on empty this degrades to a push that flags underflow
          w_top_nxt = STACK_push_value;
          if (r_empty) begin
            w_count_nxt = 16'd1;
            w_unf_nxt   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers, with full/empty precomputed so every output is a flop
  always_ff @(posedge clock) begin
    if (reset) begin
      r_top   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
      r_empty <= (w_count_nxt == 16'd0);
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign STACK_TOP       = r_top;
  assign STACK_AMOUNT    = r_count;
  assign STACK_full      = r_full;
  assign STACK_empty     = r_empty;
  assign STACK_overflow  = r_ovf;
  assign STACK_underflow = r_unf;

endmodule
